data_mem_arbiter: RTL
=====================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles with mem_clk_stall high before abort.
REQ-002 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin; 1 = port A always wins ties.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req, b_req  input  1 each  transaction request, held until the matching ack.
REQ-006 SHALL have ports a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-007 SHALL have ports a_addr, b_addr  input  32 each  byte address.
REQ-008 SHALL have ports a_wdata, b_wdata  input  32 each  write data.
REQ-009 SHALL have ports a_sign_mask, b_sign_mask  input  4 each  size/sign code passed unchanged to memory.
REQ-010 SHALL have ports a_ack, b_ack  output  1 each  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  32  read result, valid while ack is high, held until the next ack.
REQ-012 SHALL have ports mem_addr (32), mem_write_data (32), mem_sign_mask (4), mem_memread (1), mem_memwrite (1)  output  drive the data memory.
REQ-013 SHALL have ports mem_read_data  input  32 and mem_clk_stall  input  1  memory response and busy indication.
REQ-014 SHALL have ports busy  output  1 (state != IDLE), gnt_b  output  1 (0 = A owns memory, 1 = B owns memory), err  output  1 (sticky timeout flag).

Function
REQ-015 SHALL implement four states: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: if any req is high, SHALL select a winner, register its addr/wdata/sign_mask/we into the mem_* holding registers, set gnt_b, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-017 Arbitration, both reqs high: FIXED_PRIO=1 -> A wins; FIXED_PRIO=0 -> the port that is not last_gnt wins; last_gnt SHALL update on every grant.
REQ-018 ISSUE, exactly one cycle: mem_memwrite=we and mem_memread=~we; the two strobes SHALL never both be high and SHALL be low in every other state.
REQ-019 mem_addr, mem_write_data and mem_sign_mask SHALL hold their registered values from ISSUE through DONE and SHALL remain unchanged in IDLE until the next grant.
REQ-020 ISSUE -> WAIT unconditionally; the stall counter SHALL clear on entry to WAIT.
REQ-021 WAIT, mem_clk_stall=0: SHALL register mem_read_data into rdata for reads (rdata unchanged for writes) and go to DONE.
REQ-022 WAIT, mem_clk_stall=1: SHALL increment the counter; when the counter reaches TIMEOUT-1 with stall still high, SHALL set err, leave rdata unchanged, and go to DONE.
REQ-023 DONE, exactly one cycle: ack of the granted port SHALL be high and the other ack low; SHALL then return to IDLE.
REQ-024 Minimum latency: request seen in IDLE at edge N -> ack high in cycle N+3, for reads and writes alike.
REQ-025 Requester SHALL drop req in the cycle after its ack; a req still high in that IDLE cycle SHALL be treated as a new request.
REQ-026 Req changes by the non-granted port during ISSUE/WAIT/DONE SHALL be ignored; a req withdrawn before grant SHALL produce no transaction.
REQ-027 err SHALL be sticky, cleared only by reset; it SHALL NOT block further transactions.
REQ-028 Estimated RTL size 150-250 lines; single always block for the state register and counter plus output registers.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, all mem_* outputs 0, a_ack/b_ack 0, rdata 0, busy 0, gnt_b 0, err 0, counter 0, last_gnt = B (so A wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL abort it with no ack; a write already strobed may still complete inside memory, and this is accepted.

Verification
REQ-031 Single read: a_req, a_we=0, a_addr=0x10, memory word 0x12345678, stall 0 -> mem_memread pulses one cycle, a_ack in cycle N+3, rdata=0x12345678.
REQ-032 Single write with one-cycle stall: b_req, b_we=1, b_addr=0x20, b_wdata=0xCAFEF00D, sign_mask=4'b0100 -> mem_memwrite one pulse, b_ack at N+4, readback via A returns 0xCAFEF00D.
REQ-033 Round-robin: a_req and b_req held high for 4 transactions -> grant order A,B,A,B; with FIXED_PRIO=1 -> A,A,A,A.
REQ-034 Timeout: mem_clk_stall tied high, TIMEOUT=16 -> ack exactly 16 WAIT cycles after ISSUE, err=1 and remains 1; the next transaction with stall 0 completes normally.
REQ-035 Reset mid-WAIT: rst_n low during WAIT -> all outputs reach REQ-029 values without a clock edge, no ack; after release, a_req is served first on a tie.
REQ-036 Strobe check across all scenarios: mem_memread and mem_memwrite never both high; each is high for exactly one cycle per transaction.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-port (A/B) arbiter in front of a single data memory.
//               Round-robin or fixed-priority grant, one-cycle memory strobe,
//               stall wait with timeout, one-cycle ack pulse per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] b_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  a_sign_mask,
    input  logic [3:0]  b_sign_mask,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,
    output logic        busy,
    output logic        gnt_b,
    output logic        err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic             r_gnt_b;
    logic             r_last_gnt;   // 1 = B was granted last
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;

    logic             w_any_req;
    logic             w_pick_b;
    logic             w_timeout;

    // Winner selection: a lone request wins outright; on a tie either A
    // always wins or the port that did not win last time gets the grant.
    always_comb begin
        w_any_req = a_req | b_req;
        w_pick_b  = b_req;
        if (a_req && b_req) begin
            w_pick_b = FIXED_PRIO ? 1'b0 : ~r_last_gnt;
        end
        w_timeout = mem_clk_stall && (r_cnt == c_cnt_last);
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (!mem_clk_stall || w_timeout) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register, stall counter and all holding/output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_b    <= w_pick_b;
                        r_last_gnt <= w_pick_b;
                        r_we       <= w_pick_b ? b_we        : a_we;
                        r_addr     <= w_pick_b ? b_addr      : a_addr;
                        r_wdata    <= w_pick_b ? b_wdata     : a_wdata;
                        r_mask     <= w_pick_b ? b_sign_mask : a_sign_mask;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (!mem_clk_stall) begin
                        if (!r_we) begin
                            r_rdata <= mem_read_data;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes and acks decode directly from the registered state so that
    // reset clears them without waiting for a clock edge.
    assign mem_memread    = (r_state == S_ISSUE) && !r_we;
    assign mem_memwrite   = (r_state == S_ISSUE) &&  r_we;
    assign a_ack          = (r_state == S_DONE)  && !r_gnt_b;
    assign b_ack          = (r_state == S_DONE)  &&  r_gnt_b;
    assign busy           = (r_state != S_IDLE);
    assign gnt_b          = r_gnt_b;
    assign err            = r_err;
    assign rdata          = r_rdata;
    assign mem_addr       = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_sign_mask  = r_mask;

endmodule
`default_nettype wire
